// File: rtl/sin_s11_s11_pkg.sv
// Shared constants for the quarter-wave sine lookup: widths, latency,
// quadrant encodings, the 65-point coarse table and the phase fold helper.
package sin_s11_s11_pkg;

    localparam int DATA_W  = 12;
    localparam int MAG_W   = 11;
    localparam int FRAC_W  = 4;
    localparam int IDX_W   = 7;
    localparam int QTR_PTS = 65;
    localparam int LATENCY = 3;

    localparam logic [MAG_W-1:0] QTR_SPAN = 11'd1024;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    typedef struct packed {
        logic             neg;
        logic [MAG_W-1:0] x;
    } fold_t;

    // round(2047*sin(pi/2*k/64)), k = 0..64
    localparam logic [MAG_W-1:0] Q_TABLE [QTR_PTS] = '{
        11'd0,    11'd50,   11'd100,  11'd151,  11'd201,  11'd251,  11'd300,  11'd350,
        11'd399,  11'd449,  11'd497,  11'd546,  11'd594,  11'd642,  11'd690,  11'd737,
        11'd783,  11'd830,  11'd875,  11'd920,  11'd965,  11'd1009, 11'd1052, 11'd1095,
        11'd1137, 11'd1179, 11'd1219, 11'd1259, 11'd1299, 11'd1337, 11'd1375, 11'd1411,
        11'd1447, 11'd1483, 11'd1517, 11'd1550, 11'd1582, 11'd1614, 11'd1644, 11'd1674,
        11'd1702, 11'd1729, 11'd1756, 11'd1781, 11'd1805, 11'd1828, 11'd1850, 11'd1871,
        11'd1891, 11'd1910, 11'd1927, 11'd1944, 11'd1959, 11'd1973, 11'd1986, 11'd1997,
        11'd2008, 11'd2017, 11'd2025, 11'd2032, 11'd2037, 11'd2041, 11'd2045, 11'd2046,
        11'd2047
    };

    // Odd quadrants read the quarter wave backwards; the lower half-turn is positive.
    function automatic fold_t fold_phase(input logic [DATA_W-1:0] ph);
        quad_e      q;
        logic [9:0] o;
        fold_t      r;
        q     = quad_e'(ph[DATA_W-1:DATA_W-2]);
        o     = ph[9:0];
        r.neg = (q == QUAD_2) || (q == QUAD_3);
        r.x   = ((q == QUAD_1) || (q == QUAD_3)) ? (QTR_SPAN - {1'b0, o}) : {1'b0, o};
        return r;
    endfunction

endpackage

// File: rtl/sin_s11_s11_qtr.sv
// Quarter-wave magnitude M(x), x = 0..1024: registered index/fraction,
// registered table pair, then combinational linear interpolation.
module sin_s11_s11_qtr
    import sin_s11_s11_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [MAG_W-1:0] i_x,
    output logic [MAG_W-1:0] o_mag
);

    logic [IDX_W-1:0]  r_idx_p0;
    logic [FRAC_W-1:0] r_frac_p0;
    logic [MAG_W-1:0]  r_qlo_p1;
    logic [MAG_W-1:0]  r_qhi_p1;
    logic [FRAC_W-1:0] r_frac_p1;
    logic [IDX_W-1:0]  w_idx_hi;

    // Table deltas are non-negative, so the rounded step is a plain floor shift.
    function automatic logic [MAG_W-1:0] interp(input logic [MAG_W-1:0]  lo,
                                                input logic [MAG_W-1:0]  hi,
                                                input logic [FRAC_W-1:0] f);
        logic [MAG_W+FRAC_W-1:0] step;
        step = (MAG_W+FRAC_W)'(hi - lo) * (MAG_W+FRAC_W)'(f) + (MAG_W+FRAC_W)'(8);
        return lo + step[MAG_W+FRAC_W-1:FRAC_W];
    endfunction

    // x = 1024 lands on the last point with f = 0, so it reuses that point as its upper neighbour
    assign w_idx_hi = (r_idx_p0 == IDX_W'(QTR_PTS - 1)) ? r_idx_p0 : r_idx_p0 + 1'b1;

    // stage p0: split the folded angle into table index and fraction
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx_p0  <= '0;
            r_frac_p0 <= '0;
        end else begin
            r_idx_p0  <= i_x[MAG_W-1:FRAC_W];
            r_frac_p0 <= i_x[FRAC_W-1:0];
        end
    end

    // stage p1: fetch the bracketing table points
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_qlo_p1  <= '0;
            r_qhi_p1  <= '0;
            r_frac_p1 <= '0;
        end else begin
            r_qlo_p1  <= Q_TABLE[r_idx_p0];
            r_qhi_p1  <= Q_TABLE[w_idx_hi];
            r_frac_p1 <= r_frac_p0;
        end
    end

    assign o_mag = interp(r_qlo_p1, r_qhi_p1, r_frac_p1);

endmodule

// File: rtl/sin_s11_s11.sv
// Phase-to-sine converter, 3-clock latency. Defining SIN_S11_S11_COS_EN adds
// a cosine output from a second fold path over the same quarter-wave table.
module sin_s11_s11
    import sin_s11_s11_pkg::*;
(
    input  logic                     CK_i,
    input  logic                     XARST_i,
    input  logic        [DATA_W-1:0] DATs_i,
    output logic signed [DATA_W-1:0] SINs_o
`ifdef SIN_S11_S11_COS_EN
    ,
    output logic signed [DATA_W-1:0] COSs_o
`endif
);

    function automatic logic signed [DATA_W-1:0] apply_sign(input logic [MAG_W-1:0] mag,
                                                           input logic             neg);
        logic signed [DATA_W-1:0] v;
        v = signed'({1'b0, mag});
        return neg ? -v : v;
    endfunction

    fold_t            w_fold_sin;
    logic [MAG_W-1:0] w_mag_sin;
    logic             r_neg_sin_p0;
    logic             r_neg_sin_p1;
    logic signed [DATA_W-1:0] r_sin_p2;

    assign w_fold_sin = fold_phase(DATs_i);

    sin_s11_s11_qtr u_qtr_sin (
        .i_clk (CK_i),
        .i_rst (XARST_i),
        .i_x   (w_fold_sin.x),
        .o_mag (w_mag_sin)
    );

    // stage p0/p1: sign follows the magnitude pipeline; stage p2: signed output
    always_ff @(posedge CK_i or posedge XARST_i) begin
        if (XARST_i) begin
            r_neg_sin_p0 <= 1'b0;
            r_neg_sin_p1 <= 1'b0;
            r_sin_p2     <= '0;
        end else begin
            r_neg_sin_p0 <= w_fold_sin.neg;
            r_neg_sin_p1 <= r_neg_sin_p0;
            r_sin_p2     <= apply_sign(w_mag_sin, r_neg_sin_p1);
        end
    end

    assign SINs_o = r_sin_p2;

`ifdef SIN_S11_S11_COS_EN
    fold_t            w_fold_cos;
    logic [MAG_W-1:0] w_mag_cos;
    logic             r_neg_cos_p0;
    logic             r_neg_cos_p1;
    logic signed [DATA_W-1:0] r_cos_p2;

    // cos(a) = sin(a + quarter turn); the add wraps modulo one turn
    assign w_fold_cos = fold_phase(DATs_i + {1'b0, QTR_SPAN});

    sin_s11_s11_qtr u_qtr_cos (
        .i_clk (CK_i),
        .i_rst (XARST_i),
        .i_x   (w_fold_cos.x),
        .o_mag (w_mag_cos)
    );

    // stage p0/p1/p2 for the cosine path
    always_ff @(posedge CK_i or posedge XARST_i) begin
        if (XARST_i) begin
            r_neg_cos_p0 <= 1'b0;
            r_neg_cos_p1 <= 1'b0;
            r_cos_p2     <= '0;
        end else begin
            r_neg_cos_p0 <= w_fold_cos.neg;
            r_neg_cos_p1 <= r_neg_cos_p0;
            r_cos_p2     <= apply_sign(w_mag_cos, r_neg_cos_p1);
        end
    end

    assign COSs_o = r_cos_p2;
`endif

endmodule

// File: tb/tb_sin_s11_s11.sv
// Directed and sweep bench for sin_s11_s11 with an expected-value queue
// aligned to the pipeline latency.
module tb_sin_s11_s11;
    import sin_s11_s11_pkg::*;

    logic               CK_i = 1'b0;
    logic               XARST_i;
    logic        [11:0] DATs_i;
    logic signed [11:0] SINs_o;
`ifdef SIN_S11_S11_COS_EN
    logic signed [11:0] COSs_o;
`endif

    always #5 CK_i = ~CK_i;

    sin_s11_s11 dut (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .DATs_i  (DATs_i),
`ifdef SIN_S11_S11_COS_EN
        .COSs_o  (COSs_o),
`endif
        .SINs_o  (SINs_o)
    );

    typedef struct {
        int ph;
        int s;
        int c;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   qref[65];
    int   out_s[4096];

    task automatic check(input string tag, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
        end
    endtask

    function automatic int mref(input int x);
        int i, f;
        i = x >> 4;
        f = x & 15;
        if (i == 64) return 2047;
        return qref[i] + (((qref[i+1] - qref[i]) * f + 8) >> 4);
    endfunction

    function automatic int sref(input int p);
        int pp, q, o, x, m;
        pp = p & 4095;
        q  = pp >> 10;
        o  = pp & 1023;
        x  = (q & 1) ? (1024 - o) : o;
        m  = mref(x);
        return (q & 2) ? -m : m;
    endfunction

    // One negedge: check the oldest expectation, optionally release reset, drive the next phase.
    task automatic step(input int ph, input int es, input int ec, input bit rel);
        exp_t e;
        @(negedge CK_i);
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            check($sformatf("sin@%0d", e.ph), int'(SINs_o), e.s);
`ifdef SIN_S11_S11_COS_EN
            check($sformatf("cos@%0d", e.ph), int'(COSs_o), e.c);
`endif
            if (e.ph >= 0) out_s[e.ph] = int'(SINs_o);
        end
        if (rel) begin
            XARST_i = 1'b0;
            repeat (LATENCY - 1) q_exp.push_back('{-1, 0, 0});
        end
        q_exp.push_back('{ph, es, ec});
        DATs_i = 12'(ph);
    endtask

    initial begin
        bit  found;
        real id;
        int  r, d;

        for (int k = 0; k < 65; k++)
            qref[k] = $rtoi(2047.0 * $sin(3.14159265358979 * k / 128.0) + 0.5);

        XARST_i = 1'b1;
        DATs_i  = 12'd1024;
        for (int k = 0; k < 3; k++) begin
            @(negedge CK_i);
            check("rst_hold", int'(SINs_o), 0);
`ifdef SIN_S11_S11_COS_EN
            check("rst_hold_cos", int'(COSs_o), 0);
`endif
        end

        // release together with the first sample; two zero outputs precede it
        step(512,  1447, 1447, 1'b1);
        step(0,       0, 2047, 1'b0);
        step(512,  1447, 1447, 1'b0);
        step(1024, 2047,    0, 1'b0);
        step(2048,    0, -2047, 1'b0);
        step(3072, -2047,   0, 1'b0);
        step(3584, -1447, 1447, 1'b0);
        step(1,       3, 2047, 1'b0);
        step(4095,   -3, 2047, 1'b0);
        step(2047,    3, -2047, 1'b0);

        for (int p = 0; p < 4096; p++)
            step(p, sref(p), sref(p + 1024), 1'b0);
        for (int k = 0; k < 3; k++)
            step(0, 0, 2047, 1'b0);

        for (int p = 0; p < 4096; p++) begin
            id = 2047.0 * $sin(2.0 * 3.14159265358979 * p / 4096.0);
            r  = (id >= 0.0) ? $rtoi(id + 0.5) : -$rtoi(-id + 0.5);
            d  = out_s[p] - r;
            if (d < 0) d = -d;
            check($sformatf("err1lsb@%0d", p), (d <= 1) ? 1 : 0, 1);
            check($sformatf("sym_neg@%0d", p), out_s[p], -sref((4096 - p) % 4096));
            if (p >= 1 && p <= 2047)
                check($sformatf("sym_mir@%0d", p), out_s[p], sref(2048 - p));
        end

        found = 1'b0;
        for (int p = 1016; p < 1040; p++) begin
            step(p, sref(p), sref(p + 1024), 1'b0);
            if (out_s[1024] == 2047 && q_exp.size() > 0 && q_exp[0].ph == 1025) begin
                found = 1'b1;
                break;
            end
        end
        check("async_found", int'(found), 1);
        #2 XARST_i = 1'b1;
        #1 check("async_rst", int'(SINs_o), 0);
`ifdef SIN_S11_S11_COS_EN
        check("async_rst_cos", int'(COSs_o), 0);
`endif
        q_exp.delete();
        @(negedge CK_i);
        check("async_held", int'(SINs_o), 0);

        step(3072, -2047, 0, 1'b1);
        for (int k = 0; k < 3; k++)
            step(0, 0, 2047, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
